// File: rtl/updown_counter_mod_if.sv
// updown_counter_mod_if
//   Control/status bundle for the modulo-N up/down counter.
//   master : drives en, dir, clr, load, load_val, sat_mode; observes cnt_out, ovf, unf
//   slave  : the counter itself (consumes controls, produces count and event flags)
interface updown_counter_mod_if #(
  parameter int WIDTH = 4
) ();
  logic             en;
  logic             dir;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             sat_mode;
  logic [WIDTH-1:0] cnt_out;
  logic             ovf;
  logic             unf;

  modport master (
    output en, dir, clr, load, load_val, sat_mode,
    input  cnt_out, ovf, unf
  );

  modport slave (
    input  en, dir, clr, load, load_val, sat_mode,
    output cnt_out, ovf, unf
  );
endinterface

// File: rtl/updown_counter_mod.sv
// updown_counter_mod
//   Modulo-MODULUS up/down counter with enable, synchronous clear, clamped
//   parallel load, wrap/saturate mode and registered overflow/underflow pulses.
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous active-low reset (count and flags cleared)
//     bus   : slave side of updown_counter_mod_if
//             in : en, dir (1=down), clr, load, load_val, sat_mode
//             out: cnt_out (registered), ovf, unf (one-cycle registered pulses)
//   Legal parameters: WIDTH >= 1, 2 <= MODULUS <= 2**WIDTH.
module updown_counter_mod #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  updown_counter_mod_if.slave   bus
);

  // Count arithmetic and compares run one bit wider so MODULUS == 2**WIDTH
  // and out-of-range load values compare correctly.
  localparam logic [WIDTH:0] MAX_V = (WIDTH+1)'(MODULUS - 1);

  typedef struct packed {
    logic [WIDTH-1:0] cnt;
    logic             ovf;
    logic             unf;
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH:0] cnt_ext;
  logic [WIDTH:0] inc_w;
  logic [WIDTH:0] dec_w;
  logic [WIDTH:0] ld_ext;

  assign cnt_ext = {1'b0, state_q.cnt};
  assign inc_w   = cnt_ext + 1'b1;
  assign dec_w   = cnt_ext - 1'b1;
  assign ld_ext  = {1'b0, bus.load_val};

  always_comb begin
    state_d     = state_q;
    state_d.ovf = 1'b0;
    state_d.unf = 1'b0;
    if (bus.clr) begin
      state_d.cnt = '0;
    end else if (bus.load) begin
      // Out-of-range load values clamp to the top of the range.
      state_d.cnt = (ld_ext > MAX_V) ? MAX_V[WIDTH-1:0] : bus.load_val;
    end else if (bus.en) begin
      if (!bus.dir) begin
        if (cnt_ext == MAX_V) begin
          state_d.ovf = 1'b1;
          state_d.cnt = bus.sat_mode ? state_q.cnt : '0;
        end else begin
          state_d.cnt = inc_w[WIDTH-1:0];
        end
      end else begin
        if (cnt_ext == '0) begin
          state_d.unf = 1'b1;
          state_d.cnt = bus.sat_mode ? state_q.cnt : MAX_V[WIDTH-1:0];
        end else begin
          state_d.cnt = dec_w[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= '0;
    else        state_q <= state_d;
  end

  assign bus.cnt_out = state_q.cnt;
  assign bus.ovf     = state_q.ovf;
  assign bus.unf     = state_q.unf;

endmodule

// File: tb/tb_updown_counter_mod.sv
module tb_updown_counter_mod;

  logic clk;
  logic reset;

  updown_counter_mod_if #(.WIDTH(4)) if10 ();
  updown_counter_mod_if #(.WIDTH(2)) if4 ();

  updown_counter_mod #(.WIDTH(4), .MODULUS(10)) u_dut10 (
    .clk(clk), .reset(reset), .bus(if10)
  );
  updown_counter_mod #(.WIDTH(2), .MODULUS(4)) u_dut4 (
    .clk(clk), .reset(reset), .bus(if4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] cnt;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t q10[$];
  exp_t q4[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got cnt=%0d ovf=%0b unf=%0b, expected cnt=%0d ovf=%0b unf=%0b",
               name, act[5:2], act[1], act[0], req[5:2], req[1], req[0]);
    end
  endtask

  // Monitor: each edge, compare whichever DUT has a pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q10.size() > 0) begin
        e = q10.pop_front();
        chk(e.name, {if10.cnt_out, if10.ovf, if10.unf}, {e.cnt, e.ovf, e.unf});
      end
      if (q4.size() > 0) begin
        e = q4.pop_front();
        chk(e.name, {2'b00, if4.cnt_out, if4.ovf, if4.unf}, {e.cnt, e.ovf, e.unf});
      end
    end
  end

  // Drive one edge's controls on the modulus-10 counter and queue the result.
  task automatic drv10(input string nm, input logic en, dir, clr, load,
                       input logic [3:0] lv, input logic sat,
                       input logic [3:0] ecnt, input logic eovf, eunf);
    exp_t e;
    if10.en = en; if10.dir = dir; if10.clr = clr; if10.load = load;
    if10.load_val = lv; if10.sat_mode = sat;
    e.name = nm; e.cnt = ecnt; e.ovf = eovf; e.unf = eunf;
    q10.push_back(e);
  endtask

  task automatic drv4(input string nm, input logic en, dir,
                      input logic [3:0] ecnt, input logic eovf, eunf);
    exp_t e;
    if4.en = en; if4.dir = dir; if4.clr = 1'b0; if4.load = 1'b0;
    if4.load_val = '0; if4.sat_mode = 1'b0;
    e.name = nm; e.cnt = ecnt; e.ovf = eovf; e.unf = eunf;
    q4.push_back(e);
  endtask

  task automatic idle_all();
    if10.en = 0; if10.dir = 0; if10.clr = 0; if10.load = 0; if10.load_val = '0; if10.sat_mode = 0;
    if4.en = 0; if4.dir = 0; if4.clr = 0; if4.load = 0; if4.load_val = '0; if4.sat_mode = 0;
  endtask

  task automatic step10(input string nm, input logic en, dir, clr, load,
                        input logic [3:0] lv, input logic sat,
                        input logic [3:0] ecnt, input logic eovf, eunf);
    @(negedge clk);
    idle_all();
    drv10(nm, en, dir, clr, load, lv, sat, ecnt, eovf, eunf);
  endtask

  task automatic step4(input string nm, input logic en, dir,
                       input logic [3:0] ecnt, input logic eovf, eunf);
    @(negedge clk);
    idle_all();
    drv4(nm, en, dir, ecnt, eovf, eunf);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_all();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state_m10", {if10.cnt_out, if10.ovf, if10.unf}, 6'b0000_00);
    chk("reset_state_m4", {2'b00, if4.cnt_out, if4.ovf, if4.unf}, 6'b0000_00);
    @(negedge clk);
    reset = 1'b1;

    // 1: width 2, modulus 4, counting down with wrap
    step4("t1_dn_wrap0", 1, 1, 4'd3, 0, 1);
    step4("t1_dn_3to2",  1, 1, 4'd2, 0, 0);
    step4("t1_dn_2to1",  1, 1, 4'd1, 0, 0);
    step4("t1_dn_1to0",  1, 1, 4'd0, 0, 0);
    step4("t1_dn_wrap1", 1, 1, 4'd3, 0, 1);

    // 2: modulus 10, up from 0 with wrap at 9
    for (int i = 1; i <= 9; i++)
      step10("t2_up", 1, 0, 0, 0, 4'd0, 0, 4'(i), 0, 0);
    step10("t2_up_wrap", 1, 0, 0, 0, 4'd0, 0, 4'd0, 1, 0);

    // 3: saturate mode
    step10("t3_load9",    0, 0, 0, 1, 4'd9, 1, 4'd9, 0, 0);
    step10("t3_sat_dn8",  1, 1, 0, 0, 4'd0, 1, 4'd8, 0, 0);
    step10("t3_sat_dn7",  1, 1, 0, 0, 4'd0, 1, 4'd7, 0, 0);
    step10("t3_sat_dn6",  1, 1, 0, 0, 4'd0, 1, 4'd6, 0, 0);
    step10("t3_reload9",  0, 0, 0, 1, 4'd9, 1, 4'd9, 0, 0);
    step10("t3_sat_top0", 1, 0, 0, 0, 4'd0, 1, 4'd9, 1, 0);
    step10("t3_sat_top1", 1, 0, 0, 0, 4'd0, 1, 4'd9, 1, 0);

    // 4: priority and load clamp
    step10("t4_clr_wins",   1, 0, 1, 1, 4'd5,  0, 4'd0, 0, 0);
    step10("t4_clamp12",    0, 0, 0, 1, 4'd12, 0, 4'd9, 0, 0);
    step10("t4_load_no_en", 1, 0, 0, 1, 4'd3,  0, 4'd3, 0, 0);
    step10("t4_clamp15",    0, 0, 0, 1, 4'd15, 0, 4'd9, 0, 0);
    step10("t4_clr",        0, 0, 1, 0, 4'd0,  0, 4'd0, 0, 0);
    step10("t4_sat_bot0",   1, 1, 0, 0, 4'd0,  1, 4'd0, 0, 1);
    step10("t4_sat_bot1",   1, 1, 0, 0, 4'd0,  1, 4'd0, 0, 1);
    step10("t4_wrap_dn",    1, 1, 0, 0, 4'd0,  0, 4'd9, 0, 1);
    step10("t4_wrap_up",    1, 0, 0, 0, 4'd0,  0, 4'd0, 1, 0);
    step10("t4_dir_up",     1, 0, 0, 0, 4'd0,  0, 4'd1, 0, 0);
    step10("t4_dir_dn",     1, 1, 0, 0, 4'd0,  0, 4'd0, 0, 0);

    // 5: async reset mid-count, with a live flag on the small counter
    step10("t5_load6", 0, 0, 0, 1, 4'd6, 0, 4'd6, 0, 0);
    @(negedge clk);
    idle_all();
    drv10("t5_up7",   1, 0, 0, 0, 4'd0, 0, 4'd7, 0, 0);
    drv4("t5_m4_ovf", 1, 0, 4'd0, 1, 0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("t5_async_m10", {if10.cnt_out, if10.ovf, if10.unf}, 6'b0000_00);
    chk("t5_async_m4", {2'b00, if4.cnt_out, if4.ovf, if4.unf}, 6'b0000_00);
    if10.en = 1; if10.dir = 0; if10.load = 1; if10.load_val = 4'd4;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("t5_hold_rst", {if10.cnt_out, if10.ovf, if10.unf}, 6'b0000_00);
    end
    @(negedge clk);
    reset = 1'b1;
    idle_all();
    drv10("t5_first_cnt", 1, 0, 0, 0, 4'd0, 0, 4'd1, 0, 0);

    // 6: enable low, direction toggling
    step10("t6_load5", 0, 0, 0, 1, 4'd5, 0, 4'd5, 0, 0);
    for (int i = 0; i < 4; i++)
      step10("t6_hold", 0, 1'(i), 0, 0, 4'd0, 0, 4'd5, 0, 0);

    @(negedge clk);
    idle_all();
    repeat (2) @(posedge clk);
    #2;
    total++;
    if (q10.size() != 0 || q4.size() != 0) begin
      bad++;
      $display("FAIL drain: pending q10=%0d q4=%0d, expected 0", q10.size(), q4.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
